// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO drain controller: FSM encoding and
// read-path geometry.
package fifo_reader_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int READ_LAT   = 1;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus the downstream valid/ready stream of the drain controller.
// The master modport is the controller; the slave side is the FIFO and consumer.
interface fifo_reader_if #(
  parameter int DW = 15
);

  logic          empty;
  logic [DW:0]   doutb;
  logic          enb;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   out_data;
  logic          out_last;

  modport master (
    input  empty, doutb, out_ready,
    output enb, out_valid, out_data, out_last
  );

  modport slave (
    output empty, doutb, out_ready,
    input  enb, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry skid FIFO holding {last, data} words that arrive one cycle after
// their read enable; order is preserved across simultaneous push and pop.
module fifo_reader_skid #(
  parameter int DW = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        push_last,
  input  logic [DW:0] push_data,
  input  logic        pop,
  output logic [1:0]  occ,
  output logic        head_last,
  output logic [DW:0] head_data
);
  import fifo_reader_pkg::*;

  logic [DW+1:0] mem [SKID_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;

  // The parent never pushes into a full buffer without popping the same cycle,
  // so writing the slot under rd_ptr when full is safe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign {head_last, head_data} = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Drain-side FIFO controller: issues reads in fixed-length bursts, absorbs the
// one-cycle read latency in a skid buffer and presents a framed valid/ready stream.
module fifo_reader #(
  parameter int DW  = 15,
  parameter int BL  = 16,
  parameter int BCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  fifo_reader_if.master  bus,
  output logic           busy,
  output logic [BCW-1:0] burst_cnt
);
  import fifo_reader_pkg::*;

  localparam int ICW = $clog2(BL);
  localparam logic [ICW-1:0] ICNT_LAST = ICW'(BL - 1);
  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] BURST = ST_BURST;

  logic [0:0]     state;
  logic [ICW-1:0] icnt;
  logic           inflight;
  logic           inflight_last;
  logic [1:0]     occ;
  logic           pop;
  logic           issue_last;
  logic [2:0]     pending;
  logic           head_last;
  logic [DW:0]    head_data;

  assign pop        = bus.out_valid && bus.out_ready;
  assign issue_last = (icnt == ICNT_LAST);
  assign pending    = {1'b0, occ} + {2'b00, inflight};

  // A read is only issued if its word is guaranteed a skid slot; the pop term
  // lets reads resume in the same cycle the consumer frees an entry.
  assign bus.enb = rst && (state == BURST) && !bus.empty &&
                   (pending < (3'd2 + {2'b00, pop}));

  // run is only consulted in IDLE and at the last issue of a burst, so
  // dropping it mid-burst never truncates the burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      icnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= BURST;
          end
        end
        BURST: begin
          if (bus.enb) begin
            if (issue_last) begin
              icnt <= '0;
              if (!run) begin
                state <= IDLE;
              end
            end else begin
              icnt <= icnt + ICW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      inflight      <= bus.enb;
      inflight_last <= bus.enb && issue_last;
      if (pop && head_last) begin
        burst_cnt <= burst_cnt + BCW'(1);
      end
    end
  end

  fifo_reader_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_last (inflight_last),
    .push_data (bus.doutb),
    .pop       (pop),
    .occ       (occ),
    .head_last (head_last),
    .head_data (head_data)
  );

  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = head_data;
  assign bus.out_last  = head_last && bus.out_valid;
  assign busy          = (state != IDLE) || (occ != 2'd0) || inflight;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader with BL=4, BCW=2: directed bursts covering
// reset, latency, backpressure, a starved FIFO, run drop and counter wrap.
module tb_fifo_reader;

  localparam int DW  = 15;
  localparam int BL  = 4;
  localparam int BCW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           run = 1'b0;
  logic           busy;
  logic [BCW-1:0] burst_cnt;

  fifo_reader_if #(.DW(DW)) bus ();

  fifo_reader #(.DW(DW), .BL(BL), .BCW(BCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bus       (bus),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  always #5 clk = ~clk;

  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  logic [DW:0]    fifo_q [$];
  int             fifo_count = 0;
  logic           starve = 1'b0;
  logic [DW+1:0]  exp_q [$];
  int             pushed_total = 0;
  logic [BCW-1:0] exp_bcnt = '0;
  int             issued = 0;
  int             popped = 0;
  int             first_enb = -1;
  int             last_enb = -1;
  int             first_valid = -1;
  int             enb_cycles = 0;
  logic           prev_hold = 1'b0;
  logic [DW:0]    prev_data = '0;

  assign bus.empty = (fifo_count == 0) || starve;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // FIFO model: one-cycle read port.
  always @(posedge clk) begin
    cyc++;
    if (bus.enb && fifo_q.size() > 0) begin
      bus.doutb <= fifo_q.pop_front();
      fifo_count--;
    end
  end

  // Monitor: pops the scoreboard whenever the stream transfers a word.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.enb) begin
        issued++;
        enb_cycles++;
        if (first_enb < 0) first_enb = cyc;
        last_enb = cyc;
        check_output("enb_while_empty", {31'b0, bus.empty}, 32'd0);
      end
      if (bus.out_last) begin
        check_output("last_without_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      if (prev_hold) begin
        check_output("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        check_output("hold_data", {16'b0, bus.out_data}, {16'b0, prev_data});
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check_output("extra_word", popped, pushed_total);
        end else begin
          logic [DW+1:0] e;
          e = exp_q.pop_front();
          check_output("word_data", {16'b0, bus.out_data}, {16'b0, e[DW:0]});
          check_output("word_last", {31'b0, bus.out_last}, {31'b0, e[DW+1]});
          check_output("burst_cnt_seq", {30'b0, burst_cnt}, {30'b0, exp_bcnt});
          if (e[DW+1]) exp_bcnt = exp_bcnt + 2'd1;
        end
      end
      if (bus.enb || bus.out_valid) begin
        check_output("outstanding_le2", {31'b0, (issued - popped) <= 2}, 32'd1);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [DW:0] word, input logic last);
    fifo_q.push_back(word);
    fifo_count++;
    exp_q.push_back({last, word});
    pushed_total++;
  endtask

  task automatic clear_stats();
    first_enb   = -1;
    last_enb    = -1;
    first_valid = -1;
    enb_cycles  = 0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_idle(input string name, input logic toggle);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      if (toggle) starve = !starve;
      n++;
    end
    starve = 1'b0;
    check_output({name, "_timeout"}, {31'b0, n < 200}, 32'd1);
    check_output({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_issued(input int target);
    int n;
    n = 0;
    while (issued < target && n < 100) begin
      tick();
      n++;
    end
    check_output("issue_wait_timeout", {31'b0, n < 100}, 32'd1);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    rst = 1'b0;
    run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(16'(i), i == 4);
    end

    // Reset held with run high and words available.
    repeat (3) begin
      @(negedge clk);
      check_output("rst_enb", {31'b0, bus.enb}, 32'd0);
      check_output("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      check_output("rst_data", {16'b0, bus.out_data}, 32'd0);
      check_output("rst_last", {31'b0, bus.out_last}, 32'd0);
      check_output("rst_busy", {31'b0, busy}, 32'd0);
      check_output("rst_bcnt", {30'b0, burst_cnt}, 32'd0);
    end
    run = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Single burst 0x0001..0x0004.
    clear_stats();
    pulse_run();
    wait_idle("single", 1'b0);
    check_output("single_enb_count", enb_cycles, 32'd4);
    check_output("single_enb_span", last_enb - first_enb, 32'd3);
    check_output("single_latency", first_valid - first_enb, 32'd2);
    check_output("single_bcnt", {30'b0, burst_cnt}, 32'd1);

    // Backpressure: consumer stalls for 10 cycles mid-stream.
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(16'h0010 + 16'(i), i == 4);
    end
    pulse_run();
    tick();
    bus.out_ready = 1'b0;
    repeat (10) tick();
    check_output("bp_buffered", issued - popped, 32'd2);
    bus.out_ready = 1'b1;
    wait_idle("bp", 1'b0);
    check_output("bp_bcnt", {30'b0, burst_cnt}, 32'd2);

    // Starved FIFO: empty toggles every cycle.
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(16'h0020 + 16'(i), i == 4);
    end
    clear_stats();
    pulse_run();
    wait_idle("starve", 1'b1);
    check_output("starve_enb_count", enb_cycles, 32'd4);
    check_output("starve_enb_span", last_enb - first_enb, 32'd6);
    check_output("starve_bcnt", {30'b0, burst_cnt}, 32'd3);

    // Run dropped after two issues: the burst still completes.
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(16'h0030 + 16'(i), i == 4);
    end
    clear_stats();
    run = 1'b1;
    wait_issued(issued + 2);
    run = 1'b0;
    wait_idle("drop", 1'b0);
    check_output("drop_enb_count", enb_cycles, 32'd4);
    check_output("drop_bcnt_wrap", {30'b0, burst_cnt}, 32'd0);

    // Two back-to-back bursts: counter continues 1, 2 after the wrap.
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(16'h0040 + 16'(i), i == 4 || i == 8);
    end
    clear_stats();
    run = 1'b1;
    wait_issued(issued + 5);
    run = 1'b0;
    wait_idle("wrap", 1'b0);
    check_output("wrap_enb_count", enb_cycles, 32'd8);
    check_output("wrap_bcnt", {30'b0, burst_cnt}, 32'd2);
    check_output("fifo_drained", fifo_count, 32'd0);
    check_output("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
